// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register and I-bus transaction sequencer with prioritised redirects.
// Optional fetch address-error detection is enabled by defining FETCH_ADEL_EN.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        exc_valid,
  input  logic [31:0] exc_entry,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        pred_valid,
  input  logic [31:0] pred_target,
  input  logic        stall_d,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel
);

`ifdef FETCH_ADEL_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [1:0]  pend_prio_q, pend_prio_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_adel_q, out_adel_d;
  logic        adel_blk_q, adel_blk_d;

  logic        redir;
  logic [31:0] redir_tgt;
  logic [1:0]  redir_prio;
  logic        pend_wins;
  logic [31:0] merged_tgt;
  logic [1:0]  merged_prio;
  logic        issue_ok;
  logic        misaligned;
  logic        adel_fire;

  // Priority encoding: eret=3, exc=2, br=1; a held redirect survives only if strictly higher.
  always_comb begin
    redir = eret_valid | exc_valid | br_valid;
    if (eret_valid) begin
      redir_tgt  = epc;
      redir_prio = 2'd3;
    end else if (exc_valid) begin
      redir_tgt  = exc_entry;
      redir_prio = 2'd2;
    end else if (br_valid) begin
      redir_tgt  = br_target;
      redir_prio = 2'd1;
    end else begin
      redir_tgt  = br_target;
      redir_prio = 2'd0;
    end
    pend_wins   = pend_valid_q && (pend_prio_q > redir_prio);
    merged_tgt  = pend_wins ? pend_target_q : redir_tgt;
    merged_prio = pend_wins ? pend_prio_q : redir_prio;
    issue_ok    = !out_valid_q || !stall_d;
    misaligned  = ADEL_EN && (pc_q[1:0] != 2'b00);
    adel_fire   = (state_q == IDLE) && !redir && issue_ok && misaligned && !adel_blk_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!redir && issue_ok && !misaligned) state_d = ADDR;
      ADDR: if (ireq_addr_ok) state_d = (redir || pend_valid_q) ? DROP : DATA;
      DATA: begin
        if (iresp_data_ok) state_d = IDLE;
        else if (redir)    state_d = DROP;
      end
      DROP: if (iresp_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_prio_d   = pend_prio_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    out_adel_d    = out_adel_q;
    adel_blk_d    = adel_blk_q;
    if (out_valid_q && !stall_d) out_valid_d = 1'b0;
    if (redir) begin
      out_valid_d = 1'b0;
      adel_blk_d  = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (redir) begin
          pc_d = redir_tgt;
        end else if (adel_fire) begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          out_inst_d  = '0;
          out_adel_d  = 1'b1;
          adel_blk_d  = 1'b1;
        end
      end
      ADDR: begin
        if (redir) begin
          pend_valid_d  = 1'b1;
          pend_target_d = merged_tgt;
          pend_prio_d   = merged_prio;
        end
      end
      DATA: begin
        if (iresp_data_ok) begin
          if (redir) begin
            pc_d = redir_tgt;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_inst_d  = iresp_data;
            out_adel_d  = 1'b0;
            pc_d        = pred_valid ? pred_target : pc_q + 32'd4;
          end
        end else if (redir) begin
          pend_valid_d  = 1'b1;
          pend_target_d = merged_tgt;
          pend_prio_d   = merged_prio;
        end
      end
      DROP: begin
        if (iresp_data_ok) begin
          pc_d         = merged_tgt;
          pend_valid_d = 1'b0;
        end else if (redir) begin
          pend_target_d = merged_tgt;
          pend_prio_d   = merged_prio;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_prio_q   <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      out_adel_q    <= 1'b0;
      adel_blk_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_prio_q   <= pend_prio_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
      out_adel_q    <= out_adel_d;
      adel_blk_q    <= adel_blk_d;
    end
  end

  always_comb begin
    ireq_valid = (state_q == ADDR);
`ifdef FETCH_ADEL_EN
    ireq_addr  = pc_q;
`else
    ireq_addr  = {pc_q[31:2], 2'b00};
`endif
    out_valid  = out_valid_q;
    out_pc     = out_pc_q;
    out_inst   = out_inst_q;
    out_adel   = out_adel_q & ADEL_EN;
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl: sequencing, redirect priority,
// stale-response drop, decode stall, PC wrap and misaligned-fetch handling.
module tb_fetch_pc_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        eret_valid, exc_valid, br_valid, pred_valid, stall_d;
  logic [31:0] epc, exc_entry, br_target, pred_target;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic        out_adel;

  int unsigned total = 0;
  int unsigned passed = 0;

  fetch_pc_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .resetn(resetn),
    .eret_valid(eret_valid), .epc(epc),
    .exc_valid(exc_valid), .exc_entry(exc_entry),
    .br_valid(br_valid), .br_target(br_target),
    .pred_valid(pred_valid), .pred_target(pred_target),
    .stall_d(stall_d),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .ireq_addr_ok(ireq_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_adel(out_adel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    eret_valid = 0; exc_valid = 0; br_valid = 0; pred_valid = 0; stall_d = 0;
    epc = '0; exc_entry = '0; br_target = '0; pred_target = '0;
    ireq_addr_ok = 0; iresp_data_ok = 0; iresp_data = '0;
  endtask

  // Bounded wait for a bus request; the caller checks the outcome.
  task automatic wait_req(output bit ok, output logic [31:0] addr);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (ireq_valid === 1'b1) begin
        ok = 1;
        break;
      end
      step();
    end
    addr = ireq_addr;
  endtask

  // Accept the pending request, return one word on the following cycle.
  task automatic accept(input logic [31:0] data, input bit pred, input logic [31:0] ptgt);
    ireq_addr_ok = 1; step(); ireq_addr_ok = 0;
    iresp_data_ok = 1; iresp_data = data; pred_valid = pred; pred_target = ptgt;
    step();
    iresp_data_ok = 0; pred_valid = 0;
  endtask

  task automatic test_reset();
    bit ok; logic [31:0] a;
    logic [31:0] exp_pc;
    clear_inputs();
    resetn = 0;
    step(); step();
    total++;
    if ({ireq_valid, out_valid, out_adel} !== 3'b000 || out_pc !== 32'h0 || out_inst !== 32'h0)
      $display("FAIL reset_state: req=%b val=%b adel=%b pc=%h inst=%h, want all zero",
               ireq_valid, out_valid, out_adel, out_pc, out_inst);
    else passed++;
    resetn = 1;
    exp_pc = 32'hBFC0_0000;
    for (int i = 0; i < 3; i++) begin
      wait_req(ok, a);
      total++;
      if (!ok || a !== exp_pc) $display("FAIL seq_addr%0d: ok=%0d addr=%h, want %h", i, ok, a, exp_pc);
      else passed++;
      accept(32'h1111_0000 + i, 0, '0);
      total++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== 32'h1111_0000 + i)
        $display("FAIL seq_out%0d: val=%b pc=%h inst=%h, want 1 %h %h", i, out_valid, out_pc,
                 out_inst, exp_pc, 32'h1111_0000 + i);
      else passed++;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_branch_drop();
    bit ok; logic [31:0] a;
    wait_req(ok, a);
    ireq_addr_ok = 1; step(); ireq_addr_ok = 0;
    br_valid = 1; br_target = 32'h8000_1000; step(); br_valid = 0;
    step();
    iresp_data_ok = 1; iresp_data = 32'hDEAD_DEAD; step(); iresp_data_ok = 0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL br_drop_valid: out_valid=%b, want 0", out_valid);
    else passed++;
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'h8000_1000 || out_valid !== 1'b0)
      $display("FAIL br_target_addr: ok=%0d addr=%h val=%b, want 80001000 val 0", ok, a, out_valid);
    else passed++;
    accept(32'h2222_2222, 0, '0);
  endtask

  task automatic test_priority();
    bit ok; logic [31:0] a;
    wait_req(ok, a);
    ireq_addr_ok = 1; br_valid = 1; br_target = 32'h8000_2000; step();
    ireq_addr_ok = 0; br_valid = 0;
    exc_valid = 1; exc_entry = 32'hBFC0_0380; step(); exc_valid = 0;
    iresp_data_ok = 1; step(); iresp_data_ok = 0;
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'hBFC0_0380) $display("FAIL exc_over_br: ok=%0d addr=%h, want bfc00380", ok, a);
    else passed++;
    ireq_addr_ok = 1; step(); ireq_addr_ok = 0;
    eret_valid = 1; epc = 32'h8000_3000; br_valid = 1; br_target = 32'h8000_4000; step();
    eret_valid = 0;
    br_target = 32'h8000_5000; iresp_data_ok = 1; step();
    br_valid = 0; iresp_data_ok = 0;
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'h8000_3000) $display("FAIL eret_wins: ok=%0d addr=%h, want 80003000", ok, a);
    else passed++;
    ireq_addr_ok = 1; br_valid = 1; br_target = 32'h8000_6000; step();
    ireq_addr_ok = 0; br_target = 32'h8000_7000; step();
    br_valid = 0; iresp_data_ok = 1; step(); iresp_data_ok = 0;
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'h8000_7000) $display("FAIL newer_br_wins: ok=%0d addr=%h, want 80007000", ok, a);
    else passed++;
  endtask

  task automatic test_stall();
    stall_d = 1;
    accept(32'hCAFE_BABE, 0, '0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ireq_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h8000_7000 || out_inst !== 32'hCAFE_BABE)
        $display("FAIL stall_hold%0d: req=%b val=%b pc=%h inst=%h, want 0 1 80007000 cafebabe",
                 i, ireq_valid, out_valid, out_pc, out_inst);
      else passed++;
      step();
    end
    stall_d = 0; step();
    total++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'h8000_7004 || out_valid !== 1'b0)
      $display("FAIL stall_release: req=%b addr=%h val=%b, want 1 80007004 0", ireq_valid, ireq_addr, out_valid);
    else passed++;
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] a;
    ireq_addr_ok = 1; br_valid = 1; br_target = 32'hFFFF_FFFC; step();
    ireq_addr_ok = 0; br_valid = 0;
    iresp_data_ok = 1; step(); iresp_data_ok = 0;
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'hFFFF_FFFC) $display("FAIL wrap_start: ok=%0d addr=%h, want fffffffc", ok, a);
    else passed++;
    accept(32'h3333_3333, 0, '0);
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'h0000_0000 || out_pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_addr: ok=%0d addr=%h out_pc=%h, want 00000000 fffffffc", ok, a, out_pc);
    else passed++;
    accept(32'h4444_4444, 1, 32'h8000_8000);
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'h8000_8000) $display("FAIL pred_target: ok=%0d addr=%h, want 80008000", ok, a);
    else passed++;
  endtask

  task automatic test_misaligned();
    bit ok; logic [31:0] a;
    ireq_addr_ok = 1; br_valid = 1; br_target = 32'h8000_0002; step();
    ireq_addr_ok = 0; br_valid = 0;
    iresp_data_ok = 1; step(); iresp_data_ok = 0;
`ifdef FETCH_ADEL_EN
    step();
    total++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b1 || out_adel !== 1'b1 ||
        out_pc !== 32'h8000_0002 || out_inst !== 32'h0)
      $display("FAIL adel_buffer: req=%b val=%b adel=%b pc=%h inst=%h, want 0 1 1 80000002 0",
               ireq_valid, out_valid, out_adel, out_pc, out_inst);
    else passed++;
    step(); step(); step();
    total++;
    if (ireq_valid !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL adel_no_issue: req=%b val=%b, want 0 0", ireq_valid, out_valid);
    else passed++;
    exc_valid = 1; exc_entry = 32'hBFC0_0380; step(); exc_valid = 0;
    step();
    total++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 32'hBFC0_0380)
      $display("FAIL adel_recover: req=%b addr=%h, want 1 bfc00380", ireq_valid, ireq_addr);
    else passed++;
`else
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'h8000_0000 || out_adel !== 1'b0)
      $display("FAIL align_addr: ok=%0d addr=%h adel=%b, want 80000000 0", ok, a, out_adel);
    else passed++;
    accept(32'h5555_5555, 0, '0);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0002 || out_adel !== 1'b0)
      $display("FAIL align_out: val=%b pc=%h adel=%b, want 1 80000002 0", out_valid, out_pc, out_adel);
    else passed++;
    wait_req(ok, a);
    total++;
    if (!ok || a !== 32'h8000_0004) $display("FAIL align_next: ok=%0d addr=%h, want 80000004", ok, a);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_branch_drop();
    test_priority();
    test_stall();
    test_wrap();
    test_misaligned();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end
endmodule
